multi_cycle_ctrl: RTL and testbench

MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

---
 rtl/multi_cycle_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_multi_cycle_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_ctrl.sv
// rtl/multi_cycle_ctrl.sv - multi-cycle instruction sequencing controller
//
// Purpose: steps each instruction through fetch words F0..F(FETCH_WORDS-1),
// DEC, NXT, OPR, EXE, WB and END, or parks in HALTED after HLT. It issues
// registered datapath strobes, and all state changes on the falling clock edge.
//
// Ports:
//   clk        single clock, falling edge active
//   rst        synchronous active-high reset, highest priority
//   ena        run enable; low pauses with strobes forced 0 and halt held
//   zero       accumulator-zero flag (SKZ)
//   opcode     HLT/SKZ/ADD/AND/XOR/LDA/STO/JMP = 0..7
//   resume     leaves HALTED
//   mem_ready  memory handshake (only with MULTI_CYCLE_CTRL_MEM_READY_EN)
//   rd, wr, load_ir, inc_pc, load_acc, load_pc, data_ena, halt  strobes
//   ir_sel     instruction word index while fetching, 0 otherwise
//
// Optional feature macro: MULTI_CYCLE_CTRL_MEM_READY_EN

module multi_cycle_ctrl #(
    parameter int FETCH_WORDS = 2,
    parameter int SEL_W       = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             zero,
    input  logic [2:0]       opcode,
    input  logic             resume,
`ifdef MULTI_CYCLE_CTRL_MEM_READY_EN
    input  logic             mem_ready,
`endif
    output logic             rd,
    output logic             wr,
    output logic             load_ir,
    output logic             inc_pc,
    output logic             load_acc,
    output logic             load_pc,
    output logic             data_ena,
    output logic             halt,
    output logic [SEL_W-1:0] ir_sel
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DEC,
        S_NXT,
        S_OPR,
        S_EXE,
        S_WB,
        S_END,
        S_HALTED
    } state_t;

    typedef struct packed {
        logic rd;
        logic wr;
        logic load_ir;
        logic inc_pc;
        logic load_acc;
        logic load_pc;
        logic data_ena;
        logic halt;
    } ctrl_t;

    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_SKZ = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LDA = 3'b101;
    localparam logic [2:0] OP_STO = 3'b110;
    localparam logic [2:0] OP_JMP = 3'b111;

    localparam logic [SEL_W-1:0] LAST_WORD = SEL_W'(FETCH_WORDS - 1);

    state_t           state, state_n;
    logic [SEL_W-1:0] word, word_n, sel_n;
    logic             reissue, reissue_n;
    logic             stall;
    ctrl_t            ctrl, ctrl_n;

    // Strobes belonging to a state, using opcode/zero as seen on the edge
    // that issues them.
    function automatic ctrl_t decode(input state_t s, input logic [SEL_W-1:0] w,
                                     input logic [2:0] op, input logic z);
        ctrl_t c;
        logic  alu;
        logic  sto;
        logic  jmp;
        logic  skip;
        c    = '0;
        alu  = (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
        sto  = (op == OP_STO);
        jmp  = (op == OP_JMP);
        skip = (op == OP_SKZ) && z;
        case (s)
            S_FETCH: begin
                c.rd      = 1'b1;
                c.load_ir = 1'b1;
                // The PC already points at word 0 when fetching starts.
                c.inc_pc  = (w != '0);
            end
            S_DEC: ;
            S_NXT: begin
                if (op == OP_HLT) c.halt   = 1'b1;
                else              c.inc_pc = 1'b1;
            end
            S_OPR: begin
                c.load_pc  = jmp;
                c.rd       = alu;
                c.data_ena = sto;
            end
            S_EXE: begin
                c.load_acc = alu;
                c.rd       = alu;
                c.inc_pc   = jmp || skip;
                c.load_pc  = jmp;
                c.wr       = sto;
                c.data_ena = sto;
            end
            S_WB: begin
                c.data_ena = sto;
                c.rd       = alu;
            end
            S_END:    c.inc_pc = skip;
            S_HALTED: c.halt   = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

`ifdef MULTI_CYCLE_CTRL_MEM_READY_EN
    // Fetches and data-memory EXE cycles wait for the memory.
    always_comb begin
        stall = 1'b0;
        if (!mem_ready) begin
            if (state == S_FETCH) begin
                stall = 1'b1;
            end else if (state == S_EXE &&
                         (opcode == OP_ADD || opcode == OP_AND || opcode == OP_XOR ||
                          opcode == OP_LDA || opcode == OP_STO)) begin
                stall = 1'b1;
            end
        end
    end
`else
    assign stall = 1'b0;
`endif

    always_comb begin
        state_n   = state;
        word_n    = word;
        reissue_n = reissue;
        ctrl_n    = ctrl;
        if (!ena) begin
            // Paused: strobes drop, halt is kept, and the current state's
            // outputs are replayed once running again.
            reissue_n   = 1'b1;
            ctrl_n      = '0;
            ctrl_n.halt = ctrl.halt;
        end else if (reissue) begin
            // Also covers the first cycle after reset: the state is already
            // F0, only its outputs are still missing.
            reissue_n = 1'b0;
            ctrl_n    = decode(state, word, opcode, zero);
        end else if (stall) begin
            ctrl_n        = decode(state, word, opcode, zero);
            ctrl_n.inc_pc = 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (word == LAST_WORD) begin
                        state_n = S_DEC;
                        word_n  = '0;
                    end else begin
                        word_n = word + SEL_W'(1);
                    end
                end
                S_DEC:    state_n = S_NXT;
                // NXT already flagged halt when it saw HLT.
                S_NXT:    state_n = ctrl.halt ? S_HALTED : S_OPR;
                S_OPR:    state_n = S_EXE;
                S_EXE:    state_n = S_WB;
                S_WB:     state_n = S_END;
                S_END:    state_n = S_FETCH;
                S_HALTED: if (resume) state_n = S_FETCH;
                default:  state_n = S_FETCH;
            endcase
            ctrl_n = decode(state_n, word_n, opcode, zero);
        end
        sel_n = (state_n == S_FETCH) ? word_n : '0;
    end

    always_ff @(negedge clk) begin
        if (rst) begin
            state   <= S_FETCH;
            word    <= '0;
            reissue <= 1'b1;
            ctrl    <= '0;
            ir_sel  <= '0;
        end else begin
            state   <= state_n;
            word    <= word_n;
            reissue <= reissue_n;
            ctrl    <= ctrl_n;
            ir_sel  <= sel_n;
        end
    end

    assign rd       = ctrl.rd;
    assign wr       = ctrl.wr;
    assign load_ir  = ctrl.load_ir;
    assign inc_pc   = ctrl.inc_pc;
    assign load_acc = ctrl.load_acc;
    assign load_pc  = ctrl.load_pc;
    assign data_ena = ctrl.data_ena;
    assign halt     = ctrl.halt;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// tb/tb_multi_cycle_ctrl.sv - self-checking bench for multi_cycle_ctrl
module tb_multi_cycle_ctrl;

    localparam int SEL_W = 3;
`ifdef MULTI_CYCLE_CTRL_MEM_READY_EN
    localparam bit MEM_EN = 1'b1;
`else
    localparam bit MEM_EN = 1'b0;
`endif

    localparam int B_HALT = 10;
    localparam int B_RD   = 9;
    localparam int B_WR   = 8;
    localparam int B_LDIR = 7;
    localparam int B_INC  = 6;
    localparam int B_LACC = 5;
    localparam int B_LPC  = 4;
    localparam int B_DE   = 3;

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    typedef struct {
        logic [10:0] v;
        bit          mem;
        bit          enter_halt;
    } entry_t;

    logic       clk = 1'b0;
    logic       rst, ena, zero, resume, mem_ready;
    logic [2:0] opcode;
    int         cur_fw;
    logic       rst2, rst4;

    logic rd2, wr2, ldir2, inc2, lacc2, lpc2, de2, halt2;
    logic rd4, wr4, ldir4, inc4, lacc4, lpc4, de4, halt4;
    logic [SEL_W-1:0] sel2, sel4;
    logic [10:0] obs;

    // Only one instance runs at a time; the other is held in reset.
    assign rst2 = rst || (cur_fw != 2);
    assign rst4 = rst || (cur_fw != 4);
    assign obs  = (cur_fw == 4) ? {halt4, rd4, wr4, ldir4, inc4, lacc4, lpc4, de4, sel4}
                                : {halt2, rd2, wr2, ldir2, inc2, lacc2, lpc2, de2, sel2};

    always #5 clk = ~clk;

    multi_cycle_ctrl #(.FETCH_WORDS(2), .SEL_W(SEL_W)) dut2 (
        .clk(clk), .rst(rst2), .ena(ena), .zero(zero), .opcode(opcode), .resume(resume),
`ifdef MULTI_CYCLE_CTRL_MEM_READY_EN
        .mem_ready(mem_ready),
`endif
        .rd(rd2), .wr(wr2), .load_ir(ldir2), .inc_pc(inc2), .load_acc(lacc2),
        .load_pc(lpc2), .data_ena(de2), .halt(halt2), .ir_sel(sel2)
    );

    multi_cycle_ctrl #(.FETCH_WORDS(4), .SEL_W(SEL_W)) dut4 (
        .clk(clk), .rst(rst4), .ena(ena), .zero(zero), .opcode(opcode), .resume(resume),
`ifdef MULTI_CYCLE_CTRL_MEM_READY_EN
        .mem_ready(mem_ready),
`endif
        .rd(rd4), .wr(wr4), .load_ir(ldir4), .inc_pc(inc4), .load_acc(lacc4),
        .load_pc(lpc4), .data_ena(de4), .halt(halt4), .ir_sel(sel4)
    );

    // Reference model: whole instruction as a queue of per-cycle outputs.
    entry_t      q[$];
    logic [10:0] last_vec, shown;
    bit          last_mem, reissue, fresh, halted;
    int          checks, errors;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [10:0] mk(input bit h, input bit r, input bit w, input bit li,
                                       input bit ip, input bit la, input bit lp, input bit de,
                                       input int sel);
        logic [10:0] v;
        v         = '0;
        v[B_HALT] = h;
        v[B_RD]   = r;
        v[B_WR]   = w;
        v[B_LDIR] = li;
        v[B_INC]  = ip;
        v[B_LACC] = la;
        v[B_LPC]  = lp;
        v[B_DE]   = de;
        v[2:0]    = sel[2:0];
        return v;
    endfunction

    task automatic build(input logic [2:0] op, input bit z);
        bit alu, sto, jmp, skip;
        alu  = (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
        sto  = (op == OP_STO);
        jmp  = (op == OP_JMP);
        skip = (op == OP_SKZ) && z;
        for (int k = 0; k < cur_fw; k++)
            q.push_back('{mk(0, 1, 0, 1, k > 0, 0, 0, 0, k), 1'b1, 1'b0});
        q.push_back('{mk(0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b0});
        if (op == OP_HLT) begin
            q.push_back('{mk(1, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b0});
            q.push_back('{mk(1, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b1});
            return;
        end
        q.push_back('{mk(0, 0, 0, 0, 1, 0, 0, 0, 0), 1'b0, 1'b0});
        q.push_back('{mk(0, alu, 0, 0, 0, 0, jmp, sto, 0), 1'b0, 1'b0});
        q.push_back('{mk(0, alu, sto, 0, jmp || skip, alu, jmp, sto, 0), alu || sto, 1'b0});
        q.push_back('{mk(0, alu, 0, 0, 0, 0, 0, sto, 0), 1'b0, 1'b0});
        q.push_back('{mk(0, 0, 0, 0, skip, 0, 0, 0, 0), 1'b0, 1'b0});
    endtask

    task automatic advance(output logic [10:0] e);
        entry_t x;
        if (q.size() == 0) build(opcode, zero);
        x        = q.pop_front();
        last_vec = x.v;
        last_mem = x.mem;
        fresh    = 1'b0;
        if (x.enter_halt) halted = 1'b1;
        e = x.v;
    endtask

    task automatic model_edge(output logic [10:0] e);
        if (rst) begin
            q.delete();
            last_vec = '0;
            last_mem = 1'b0;
            reissue  = 1'b0;
            fresh    = 1'b1;
            halted   = 1'b0;
            e        = '0;
        end else if (!ena) begin
            if (!fresh) reissue = 1'b1;
            e         = '0;
            e[B_HALT] = shown[B_HALT];
            e[2:0]    = last_vec[2:0];
        end else if (reissue) begin
            reissue = 1'b0;
            e       = last_vec;
        end else if (halted) begin
            if (resume) begin
                halted = 1'b0;
                advance(e);
            end else begin
                e = last_vec;
            end
        end else if (MEM_EN && last_mem && !mem_ready) begin
            e        = last_vec;
            e[B_INC] = 1'b0;
        end else begin
            advance(e);
        end
        shown = e;
    endtask

    task automatic step(input string tag);
        logic [10:0] e;
        model_edge(e);
        @(negedge clk);
        #1;
        check_eq(tag, obs, e);
    endtask

    task automatic do_reset(input int w);
        cur_fw    = w;
        rst       = 1'b1;
        ena       = 1'b1;
        resume    = 1'b0;
        mem_ready = 1'b1;
        step("reset");
        check_eq("reset_outs", obs, 0);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0]  acc_h, ldir_h;
        logic [11:0] sel_h;
        logic [3:0]  inc_h;
        logic [2:0]  mi_h, mr_h;
        int          n;

        checks = 0; errors = 0;
        rst = 1'b1; ena = 1'b1; zero = 1'b0; resume = 1'b0; mem_ready = 1'b1;
        opcode = OP_LDA; cur_fw = 2;
        shown = '0; last_vec = '0;

        // LDA after reset: nine cycles back to F0, load_acc only in EXE.
        do_reset(2);
        opcode = OP_LDA; zero = 1'b0;
        for (int i = 0; i < 9; i++) begin
            step("lda");
            acc_h[i]  = obs[B_LACC];
            ldir_h[i] = obs[B_LDIR];
        end
        check_eq("lda_load_acc", acc_h, 9'b000100000);
        check_eq("lda_load_ir", ldir_h, 9'b100000011);

        // Four-word fetch.
        do_reset(4);
        opcode = OP_ADD;
        for (int i = 0; i < 4; i++) begin
            step("add4");
            sel_h[i*3 +: 3] = obs[2:0];
            inc_h[i]        = obs[B_INC];
        end
        check_eq("add4_ir_sel", sel_h, 12'h688);
        check_eq("add4_inc", inc_h, 4'b1110);
        step("add4_dec");
        step("add4_nxt");
        check_eq("add4_nxt_inc", obs[B_INC], 1);

        // Halt and resume.
        do_reset(2);
        opcode = OP_HLT;
        for (int i = 0; i < 4; i++) step("hlt");
        check_eq("hlt_nxt_halt", obs[B_HALT], 1);
        for (int i = 0; i < 5; i++) begin
            step("hlt_wait");
            check_eq("hlt_hold", obs[B_HALT], 1);
        end
        resume = 1'b1;
        step("hlt_resume");
        check_eq("resume_halt", obs[B_HALT], 0);
        check_eq("resume_f0", {obs[B_LDIR], obs[2:0]}, 4'b1000);
        resume = 1'b0;

        // SKZ with zero clear and set.
        for (int zz = 0; zz < 2; zz++) begin
            do_reset(2);
            opcode = OP_SKZ; zero = zz[0];
            n = 0;
            for (int i = 0; i < 8; i++) begin
                step("skz");
                if (i >= 2) n += int'(obs[B_INC]);
            end
            check_eq("skz_inc_pulses", n, (zz == 1) ? 3 : 1);
        end
        zero = 1'b0;

        // Pause in STO's EXE, then reset during WB.
        do_reset(2);
        opcode = OP_STO;
        for (int i = 0; i < 6; i++) step("sto");
        check_eq("sto_exe_wr", obs[B_WR], 1);
        ena = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step("sto_pause");
            check_eq("sto_pause_wr", obs[B_WR], 0);
        end
        ena = 1'b1;
        step("sto_reissue");
        check_eq("sto_reissue_wr_de", {obs[B_WR], obs[B_DE]}, 2'b11);
        step("sto_wb");
        check_eq("sto_wb_de", obs[B_DE], 1);
        rst = 1'b1;
        step("rst_wb");
        check_eq("rst_wb_outs", obs, 0);
        rst = 1'b0;

`ifdef MULTI_CYCLE_CTRL_MEM_READY_EN
        // Wait states during the second fetch word.
        do_reset(2);
        opcode = OP_LDA;
        step("mr_f0");
        step("mr_f1");
        mi_h[0] = obs[B_INC];
        mr_h[0] = obs[B_LDIR];
        mem_ready = 1'b0;
        for (int i = 1; i < 3; i++) begin
            step("mr_wait");
            mi_h[i] = obs[B_INC];
            mr_h[i] = obs[B_LDIR];
        end
        mem_ready = 1'b1;
        step("mr_dec");
        check_eq("mr_inc", mi_h, 3'b001);
        check_eq("mr_load_ir", mr_h, 3'b111);
        check_eq("mr_dec_load_ir", obs[B_LDIR], 0);
`else
        mi_h = '0;
        mr_h = '0;
`endif

        // Random traffic on both fetch widths.
        for (int pass = 0; pass < 2; pass++) begin
            do_reset((pass == 0) ? 2 : 4);
            for (int i = 0; i < 400; i++) begin
                rst       = ($urandom_range(0, 49) == 0);
                ena       = ($urandom_range(0, 7) != 0);
                resume    = ($urandom_range(0, 3) == 0);
                mem_ready = MEM_EN ? ($urandom_range(0, 3) != 0) : 1'b1;
                if (ena && q.size() == 0 && !reissue) begin
                    opcode = 3'($urandom_range(0, 7));
                    zero   = 1'($urandom_range(0, 1));
                end
                step("random");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
